jnt_trig_unit: RTL and testbench

JNT_TRIG_UNIT -- requirements
Module: jnt_trig_unit

---
 rtl/trig_pkg.sv | 64 ++++++
 rtl/trig_lut.sv | 36 +++
 rtl/jnt_trig_unit.sv | 141 ++++++++++++++
 tb/tb_jnt_trig_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// ============================================================================
// trig_pkg: shared widths, constants, FSM states and cosine-point generator
// Rev 1.0
// ============================================================================
`default_nettype none

package trig_pkg;

    localparam int ANGLE_W = 32;
    localparam int IDX_W   = 12;
    localparam int FRAC_W  = 30;

    localparam logic [31:0] QUARTER_TURN = 32'h4000_0000;
    localparam longint      SAT_MAX      = 64'sd1 <<< FRAC_W;
    localparam longint      SAT_MIN      = -SAT_MAX;
    localparam longint      PI_FRAC      = 64'sd3373259426;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_MAC  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // cos(2*pi*j/2^idx_w) in Q2.FRAC_W: Taylor series over one quadrant, then
    // quadrant symmetry so the table endpoints at 0, pi/2, pi, 3pi/2 are exact.
    function automatic logic signed [31:0] cos_point(input int j, input int idx_w);
        int     q;
        int     r;
        longint x;
        longint x2;
        longint tc;
        longint ts;
        longint c;
        longint s;
        longint v;
        q  = (j >> (idx_w - 2)) & 3;
        r  = j & ((1 << (idx_w - 2)) - 1);
        x  = (longint'(r) * PI_FRAC + (64'sd1 <<< (idx_w - 2))) >>> (idx_w - 1);
        x2 = (x * x + (64'sd1 <<< (FRAC_W - 1))) >>> FRAC_W;
        tc = 64'sd1 <<< FRAC_W;
        ts = x;
        c  = tc;
        s  = ts;
        for (int k = 1; k <= 10; k++) begin
            tc = -((tc * x2) >>> FRAC_W) / longint'((2 * k - 1) * (2 * k));
            ts = -((ts * x2) >>> FRAC_W) / longint'((2 * k) * (2 * k + 1));
            c  = c + tc;
            s  = s + ts;
        end
        case (q)
            0:       v = c;
            1:       v = -s;
            2:       v = -c;
            default: v = s;
        endcase
        if (v > SAT_MAX) v = SAT_MAX;
        if (v < SAT_MIN) v = SAT_MIN;
        return 32'(v);
    endfunction

endpackage

`default_nettype wire

// File: rtl/trig_lut.sv
// ============================================================================
// trig_lut: synchronous ROM of cosine gradient/intercept pairs per segment
// Rev 1.0
// ============================================================================
`default_nettype none

module trig_lut #(
    parameter int IDX_W = 12
) (
    input  logic                clk,
    input  logic [IDX_W-1:0]    addr,
    output logic signed [31:0]  grad,
    output logic signed [31:0]  icpt
);
    import trig_pkg::*;

    localparam int DEPTH = 1 << IDX_W;

    logic [63:0] rom [DEPTH];

    // Intercept is the segment start point; gradient spans to the next point,
    // wrapping the last segment back onto cos(0).
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic signed [31:0] B_VAL = cos_point(i, IDX_W);
        localparam logic signed [31:0] M_VAL = cos_point((i + 1) % DEPTH, IDX_W) - B_VAL;
        assign rom[i] = {M_VAL, B_VAL};
    end

    always_ff @(posedge clk) begin
        grad <= rom[addr][63:32];
        icpt <= rom[addr][31:0];
    end

endmodule

`default_nettype wire

// File: rtl/jnt_trig_unit.sv
// ============================================================================
// jnt_trig_unit: cos/sin of three joint angles through one shared LUT + MAC
// Rev 1.0
// ============================================================================
`default_nettype none

module jnt_trig_unit #(
    parameter int ANGLE_W = 32,
    parameter int IDX_W   = 12,
    parameter int FRAC_W  = 30
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ANGLE_W-1:0]  jnt0,
    input  logic [ANGLE_W-1:0]  jnt1,
    input  logic [ANGLE_W-1:0]  jnt2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [31:0]  cos0,
    output logic signed [31:0]  cos1,
    output logic signed [31:0]  cos2,
    output logic signed [31:0]  sin0,
    output logic signed [31:0]  sin1,
    output logic signed [31:0]  sin2
);
    import trig_pkg::*;

    localparam int     OFF_W  = ANGLE_W - IDX_W;
    localparam longint SAT_HI = 64'sd1 <<< FRAC_W;
    localparam longint SAT_LO = -SAT_HI;

    state_t                 r_state;
    logic [2:0]             r_cnt;
    logic [ANGLE_W-1:0]     r_jnt [3];
    logic signed [31:0]     r_res [6];

    logic [ANGLE_W-1:0]     w_base;
    logic [ANGLE_W-1:0]     w_angle;
    logic [IDX_W-1:0]       w_index;
    logic [OFF_W-1:0]       w_offset;
    logic signed [31:0]     w_grad;
    logic signed [31:0]     w_icpt;
    logic signed [63:0]     w_prod;
    logic signed [63:0]     w_sum;
    logic signed [31:0]     w_sat;

    // Evaluation k: joint k/2, odd k is the sine (cosine a quarter turn back).
    always_comb begin
        w_base = r_jnt[2];
        case (r_cnt[2:1])
            2'd0:    w_base = r_jnt[0];
            2'd1:    w_base = r_jnt[1];
            default: w_base = r_jnt[2];
        endcase
    end

    assign w_angle  = r_cnt[0] ? (w_base - ANGLE_W'(QUARTER_TURN)) : w_base;
    assign w_index  = w_angle[ANGLE_W-1 -: IDX_W];
    assign w_offset = w_angle[OFF_W-1:0];

    trig_lut #(
        .IDX_W (IDX_W)
    ) u_lut (
        .clk   (clk),
        .addr  (w_index),
        .grad  (w_grad),
        .icpt  (w_icpt)
    );

    assign w_prod = 64'(w_grad) * 64'($signed({1'b0, w_offset}));
    assign w_sum  = 64'(w_icpt) + (w_prod >>> OFF_W);

    always_comb begin
        w_sat = w_sum[31:0];
        if (w_sum > SAT_HI) begin
            w_sat = 32'(SAT_HI);
        end else if (w_sum < SAT_LO) begin
            w_sat = 32'(SAT_LO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 3'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            for (int i = 0; i < 3; i++) r_jnt[i] <= '0;
            for (int i = 0; i < 6; i++) r_res[i] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_jnt[0] <= jnt0;
                        r_jnt[1] <= jnt1;
                        r_jnt[2] <= jnt2;
                        r_cnt    <= 3'd0;
                        in_ready <= 1'b0;
                        r_state  <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    r_state <= ST_MAC;
                end
                ST_MAC: begin
                    r_res[r_cnt] <= w_sat;
                    if (r_cnt == 3'd5) begin
                        r_cnt     <= 3'd0;
                        out_valid <= 1'b1;
                        r_state   <= ST_OUT;
                    end else begin
                        r_cnt   <= r_cnt + 3'd1;
                        r_state <= ST_ADDR;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cos0 = r_res[0];
    assign sin0 = r_res[1];
    assign cos1 = r_res[2];
    assign sin1 = r_res[3];
    assign cos2 = r_res[4];
    assign sin2 = r_res[5];

endmodule

`default_nettype wire

// File: tb/tb_jnt_trig_unit.sv
// ============================================================================
// tb_jnt_trig_unit: scoreboard bench against a real-valued cos/sin model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_jnt_trig_unit;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [31:0]        jnt0 = '0;
    logic [31:0]        jnt1 = '0;
    logic [31:0]        jnt2 = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [31:0] cos0, cos1, cos2, sin0, sin1, sin2;
    logic signed [31:0] outs [6];

    jnt_trig_unit #(
        .ANGLE_W (32),
        .IDX_W   (12),
        .FRAC_W  (30)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .jnt0      (jnt0),
        .jnt1      (jnt1),
        .jnt2      (jnt2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cos0      (cos0),
        .cos1      (cos1),
        .cos2      (cos2),
        .sin0      (sin0),
        .sin1      (sin1),
        .sin2      (sin2)
    );

    always #5 clk = ~clk;

    int unsigned edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    always_comb begin
        outs[0] = cos0;
        outs[1] = sin0;
        outs[2] = cos1;
        outs[3] = sin1;
        outs[4] = cos2;
        outs[5] = sin2;
    end

    int checks   = 0;
    int failures = 0;
    bit abort    = 1'b0;

    typedef struct {
        int unsigned      acc;
        logic [2:0][31:0] a;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic real ideal(input logic [31:0] a, input bit is_sin);
        real th;
        th = 6.283185307179586 * real'(a) / 4294967296.0;
        return (is_sin ? $sin(th) : $cos(th)) * 1073741824.0;
    endfunction

    task automatic check_trig(input string name, input logic signed [31:0] act,
                              input logic [31:0] a, input bit is_sin);
        real id;
        real err;
        id  = ideal(a, is_sin);
        err = real'(act) - id;
        checks++;
        if (err > 512.0 || err < -512.0 || act > 32'sd1073741824 || act < -32'sd1073741824) begin
            failures++;
            $display("FAIL %s angle=%h: actual=%0d required=%0d (+/-512)", name, a, act, $rtoi(id));
        end
    endtask

    // Monitor: pops the scoreboard when a result appears, then tracks the hold and handshake.
    bit                 busy = 1'b0;
    bit                 hs_pend = 1'b0;
    logic signed [31:0] snap [6];

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                busy    = 1'b0;
                hs_pend = 1'b0;
            end else begin
                if (hs_pend) begin
                    check(out_valid == 1'b0, "valid_drop_after_hs", longint'(out_valid), 0);
                    check(in_ready == 1'b1, "in_ready_after_hs", longint'(in_ready), 1);
                    hs_pend = 1'b0;
                    busy    = 1'b0;
                end
                if (!busy) begin
                    if (out_valid) begin
                        if (sbq.size() == 0) begin
                            check(1'b0, "unexpected_out_valid", 1, 0);
                        end else begin
                            exp_t e;
                            e = sbq.pop_front();
                            check(edge_n - e.acc == 12, "latency", longint'(edge_n - e.acc), 12);
                            for (int j = 0; j < 3; j++) begin
                                check_trig($sformatf("cos%0d", j), outs[2*j],   e.a[j], 1'b0);
                                check_trig($sformatf("sin%0d", j), outs[2*j+1], e.a[j], 1'b1);
                            end
                        end
                        busy = 1'b1;
                        for (int i = 0; i < 6; i++) snap[i] = outs[i];
                    end
                end else begin
                    check(out_valid == 1'b1, "valid_held", longint'(out_valid), 1);
                    check(in_ready == 1'b0, "in_ready_low_while_valid", longint'(in_ready), 0);
                    for (int i = 0; i < 6; i++)
                        check(outs[i] == snap[i], $sformatf("hold_out%0d", i), longint'(outs[i]), longint'(snap[i]));
                end
                if (busy && out_ready) hs_pend = 1'b1;
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after the accepting edge.
    task automatic send(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
        int   n;
        exp_t e;
        n = 0;
        if (abort) return;
        while (!in_ready) begin
            if (n >= 200) begin
                check(1'b0, "in_ready_timeout", longint'(in_ready), 1);
                abort = 1'b1;
                return;
            end
            n++;
            @(negedge clk);
        end
        jnt0     = a0;
        jnt1     = a1;
        jnt2     = a2;
        in_valid = 1'b1;
        e.acc    = edge_n + 1;
        e.a[0]   = a0;
        e.a[1]   = a1;
        e.a[2]   = a2;
        sbq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sbq.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            check(1'b0, "drain_timeout", longint'(sbq.size()), 0);
            abort = 1'b1;
        end
    endtask

    initial begin
        int n;
        #2 rst_n = 1'b0;
        #1;
        check(in_ready == 1'b1, "reset_in_ready", longint'(in_ready), 1);
        check(out_valid == 1'b0, "reset_out_valid", longint'(out_valid), 0);
        for (int i = 0; i < 6; i++)
            check(outs[i] == 0, $sformatf("reset_out%0d", i), longint'(outs[i]), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check(in_ready == 1'b1, "in_ready_after_release", longint'(in_ready), 1);

        send(32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        send(32'h4000_0000, 32'h8000_0000, 32'hC000_0000);
        send(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        send(32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF);
        wait_idle();

        // Output stall: results must freeze while the consumer holds off.
        out_ready = 1'b0;
        send($urandom, $urandom, $urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(out_valid == 1'b1, "stall_valid_seen", longint'(out_valid), 1);
        repeat (20) @(negedge clk);
        out_ready = 1'b1;
        wait_idle();

        // Reset in the middle of an evaluation drops the transaction.
        send($urandom, $urandom, $urandom);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check(out_valid == 1'b0, "midreset_out_valid", longint'(out_valid), 0);
        check(in_ready == 1'b1, "midreset_in_ready", longint'(in_ready), 1);
        for (int i = 0; i < 6; i++)
            check(outs[i] == 0, $sformatf("midreset_out%0d", i), longint'(outs[i]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check(out_valid == 1'b0, "no_valid_after_midreset", longint'(out_valid), 0);
        send(32'h2000_0000, 32'h1234_5678, 32'hDEAD_BEEF);
        wait_idle();

        // Back-to-back random sweep: three angles per transaction, ~10k angles.
        for (int t = 0; t < 3334; t++) begin
            if (abort) break;
            send($urandom, $urandom, $urandom);
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
